// File: rtl/uart_pkg.sv
// Shared UART constants and the byte-level receive/transmit state set.
// Imported by both the 16-bit receiver and transmitter.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int WORD_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchronizer plus bit-timing FSM.
// Emits a one-cycle byte_valid or framing_error after the stop bit.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 byte_valid,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 framing_error,
  output logic                 line_idle
);

  localparam logic [CNT_W-1:0] HALF =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_m, rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) state_d = STOP;
          else bit_d = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          valid_d = rx_s;
          ferr_d  = !rx_s;
          state_d = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // no new start until the line returns high
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign byte_valid    = valid_q;
  assign byte_data     = shift_q;
  assign framing_error = ferr_q;
  assign line_idle     = (state_q == IDLE);

endmodule

// File: rtl/uart_rx16.sv
// 8N1 receiver pairing two bytes (low first) into a 16-bit word,
// with ready/ack handshake, overrun flag and inter-byte timeout.
module uart_rx16
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT      = 5208,
  parameter int BYTE_TIMEOUT_BITS = 20
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx,
  input  logic                            read_ack,
  output logic [DATA_BITS*WORD_BYTES-1:0] data_received,
  output logic                            data_ready_to_read,
  output logic                            framing_error,
  output logic                            overrun
);

  localparam int TMO   = CLKS_PER_BIT * BYTE_TIMEOUT_BITS;
  localparam int CNT_W = $clog2(TMO + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 1);

  logic                 byte_valid;
  logic [DATA_BITS-1:0] byte_data;
  logic                 ferr;
  logic                 line_idle;
  logic                 byte_cnt;
  logic [DATA_BITS-1:0] low_q;
  logic [CNT_W-1:0]     tmo_q;
  logic                 word_done;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_byte (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .framing_error (ferr),
    .line_idle     (line_idle)
  );

  assign framing_error = ferr;
  assign word_done     = byte_valid && byte_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 1'b0;
      low_q    <= '0;
      tmo_q    <= '0;
    end else if (byte_valid) begin
      tmo_q <= '0;
      if (!byte_cnt) begin
        low_q    <= byte_data;
        byte_cnt <= 1'b1;
      end else begin
        byte_cnt <= 1'b0;
      end
    end else if (ferr) begin
      byte_cnt <= 1'b0;
      tmo_q    <= '0;
    end else if (line_idle && byte_cnt) begin
      // stale low byte is dropped silently
      if (tmo_q == TMO_LAST) begin
        byte_cnt <= 1'b0;
        tmo_q    <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end else begin
      tmo_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_received      <= '0;
      data_ready_to_read <= 1'b0;
      overrun            <= 1'b0;
    end else if (word_done) begin
      data_received      <= {byte_data, low_q};
      data_ready_to_read <= 1'b1;
      if (data_ready_to_read) overrun <= !read_ack;
    end else if (read_ack && data_ready_to_read) begin
      data_ready_to_read <= 1'b0;
      overrun            <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx16.md
Name: uart_rx16

Overview:
- 8N1 UART receiver. Assembles two consecutive bytes, low byte first, into one 16-bit word.
- Receive-side counterpart of the 16-bit UART transmitter; sits between the rx pin and the consumer of received words.
- Runs on the system clock. Bit timing comes from the CLKS_PER_BIT divider.
- Holds each word with a ready/ack handshake and flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud); must be >= 4.
- BYTE_TIMEOUT_BITS, 20, bit-times allowed in idle between low and high byte before the pending low byte is discarded.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- read_ack  input  1  one-cycle pulse: consumer has taken data_received
- data_received  output  16  last complete word {high byte, low byte}
- data_ready_to_read  output  1  level: unread word present
- framing_error  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  sticky: a word was overwritten before read_ack

Behaviour:
- Reset (async) values:
  - data_received = 0, data_ready_to_read = 0, framing_error = 0, overrun = 0.
  - Synchronizer flops = 1, state = IDLE, byte_cnt = 0, all counters = 0.
- rx passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s.
- Byte FSM:
  - IDLE: rx_s == 0 -> START, bit counter cleared.
  - START: at count CLKS_PER_BIT/2-1 (integer division), sample rx_s. If 0 -> DATA, counter cleared. If 1 -> IDLE (glitch rejected, no flag).
  - DATA: every CLKS_PER_BIT clocks, sample rx_s into the shift register, LSB first. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT clocks, sample rx_s.
    - 1: byte valid -> IDLE.
    - 0: pulse framing_error, byte_cnt <= 0, -> BREAK.
  - BREAK: wait for rx_s == 1, then -> IDLE (no restart while the line is held low).
- Word assembly:
  - Valid byte with byte_cnt = 0: store as low byte, byte_cnt <= 1, clear timeout counter.
  - Valid byte with byte_cnt = 1: data_received <= {byte, low}, byte_cnt <= 0. data_ready_to_read = 1 on the clock after the stop-bit sample edge (latency 1 clock).
- Timeout:
  - Counts only in IDLE while byte_cnt = 1.
  - At BYTE_TIMEOUT_BITS*CLKS_PER_BIT clocks: byte_cnt <= 0, low byte discarded, no flag.
- Handshake:
  - read_ack clears data_ready_to_read and overrun on the next edge.
  - read_ack while data_ready_to_read = 0 is ignored.
  - data_received is stable between completions and is never cleared by read_ack.
- Simultaneous events:
  - Completion and read_ack in the same cycle: data updated, data_ready_to_read stays 1, overrun not set.
  - Completion while data_ready_to_read = 1 without read_ack: data overwritten, overrun <= 1.
- Counter width: $clog2(CLKS_PER_BIT*BYTE_TIMEOUT_BITS+1). No wrap occurs; each counter is cleared on every state change.
- Reset mid-frame: the frame is abandoned. A receive resumes only at the next falling edge after reset deasserts. The partial word is lost.

Decomposition:
- Shared package uart_pkg:
  - byte-FSM state enum (IDLE, START, DATA, STOP, BREAK)
  - DATA_BITS = 8
  - WORD_BYTES = 2
  - these constants are reused by the 16-bit transmitter
- One sub-module, uart_rx_byte:
  - contains the synchronizer and the byte FSM
  - outputs byte_valid (pulse), byte_data[7:0], framing_error
- uart_rx16 contains byte assembly, timeout, handshake and overrun logic.

Test Plan:
(Bench uses CLKS_PER_BIT = 16, BYTE_TIMEOUT_BITS = 20.)
- Send bytes 0x34 then 0x12 back-to-back -> data_received = 0x1234, data_ready_to_read = 1 one clock after the second stop-bit sample; read_ack -> ready = 0, data still 0x1234.
- rx low for 4 clocks, then high -> no state beyond START, no flags; a following 0xEF, 0xBE -> data_received = 0xBEEF.
- First byte 0x55 with stop bit 0, line held low 40 clocks, then 0xCD, 0xAB -> exactly one framing_error pulse, no spurious start during low period, data_received = 0xABCD.
- Send 0x11, idle 400 clocks (> 320 timeout), then 0x22, 0x33 -> data_received = 0x3322, never 0x2211.
- Receive 0x1234, no ack, receive 0x5678 -> data_received = 0x5678, overrun = 1; read_ack -> overrun = 0, ready = 0. Repeat with read_ack on the completion cycle -> overrun stays 0, ready = 1.
- Assert reset during DATA of the high byte -> all outputs 0 immediately (async); after release, 0xAD then 0xDE -> 0xDEAD.
